// File: rtl/openram_tc_pkg.sv
// Shared types and constants for the OpenRAM test-chip Wishbone port.
// Optional build macro: OPENRAM_WB_BYTE_MASK_EN (byte-masked writes).
package openram_tc_pkg;

  localparam int          WB_DATA_W       = 32;
  localparam int          WB_SEL_W        = 4;
  localparam logic [31:0] DEFAULT_BASE    = 32'h3000_0000;
  // Macro index 0 on the bus is physical SRAM 8 on the die.
  localparam int          SRAM_IDX_OFFSET = 8;
  localparam int          CNT_W           = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} wb_state_e;

endpackage

// File: rtl/openram_wb_decode.sv
// Address decode for the OpenRAM port: base hit, macro index, word address.
// Optional build macro: OPENRAM_WB_BYTE_MASK_EN (not used here).
module openram_wb_decode
  import openram_tc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE,
  parameter int          NUM_SRAM  = 5,
  parameter int          ADDR_W    = 8,
  parameter int          SEL_W     = 3
) (
  input  logic [31:0]       adr_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic [ADDR_W-1:0] word_o,
  output logic              idx_valid_o
);

  assign hit_o       = (adr_i[31:24] == BASE_ADDR[31:24]);
  assign idx_o       = adr_i[ADDR_W+2 +: SEL_W];
  assign word_o      = adr_i[ADDR_W+1:2];
  assign idx_valid_o = (int'(idx_o) < NUM_SRAM);

  // Byte offset and the gap between the index field and the base byte are don't-care.
  logic unused_adr;
  assign unused_adr = ^{adr_i[23:ADDR_W+2+SEL_W], adr_i[1:0]};

endmodule

// File: rtl/openram_wb_port.sv
// Wishbone slave that turns one bus access into a single-cycle OpenRAM command.
// Optional build macro: OPENRAM_WB_BYTE_MASK_EN (byte-masked writes; default full-word only).
module openram_wb_port
  import openram_tc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE,
  parameter int          NUM_SRAM  = 5,
  parameter int          ADDR_W    = 8,
  parameter int          SEL_W     = 3,
  parameter int          READ_LAT  = 1
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_we_i,
  input  logic [WB_SEL_W-1:0]             wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [WB_DATA_W-1:0]            wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [WB_DATA_W-1:0]            wbs_dat_o,
  output logic [NUM_SRAM-1:0]             sram_csb_o,
  output logic                            sram_web_o,
  output logic [WB_SEL_W-1:0]             sram_wmask_o,
  output logic [ADDR_W-1:0]               sram_addr_o,
  output logic [WB_DATA_W-1:0]            sram_din_o,
  input  logic [NUM_SRAM*WB_DATA_W-1:0]   sram_dout_i
);

  wb_state_e state_q, state_d;

  logic                 we_q, we_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic [WB_DATA_W-1:0] dat_q, dat_d;
  logic [NUM_SRAM-1:0]  csb_q, csb_d;
  logic                 web_q, web_d;
  logic [WB_SEL_W-1:0]  wmask_q, wmask_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WB_DATA_W-1:0] din_q, din_d;

  logic                 hit, idx_valid, accept, wr_drop;
  logic [SEL_W-1:0]     dec_idx;
  logic [ADDR_W-1:0]    dec_word;
  logic [WB_SEL_W-1:0]  wr_mask;
  logic [WB_DATA_W-1:0] rd_word;

  openram_wb_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_SRAM  (NUM_SRAM),
    .ADDR_W    (ADDR_W),
    .SEL_W     (SEL_W)
  ) u_decode (
    .adr_i       (wbs_adr_i),
    .hit_o       (hit),
    .idx_o       (dec_idx),
    .word_o      (dec_word),
    .idx_valid_o (idx_valid)
  );

  // Holding off while ack is high forces one idle cycle between back-to-back strobes.
  assign accept = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i && hit && !ack_q;

`ifdef OPENRAM_WB_BYTE_MASK_EN
  assign wr_mask = wbs_sel_i;
  assign wr_drop = (wbs_sel_i == '0);
`else
  assign wr_mask = '1;
  assign wr_drop = (wbs_sel_i != '1);
`endif

  // Out-of-range index matches no macro and reads back as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_SRAM; i++)
      if (idx_q == SEL_W'(i)) rd_word = sram_dout_i[i*WB_DATA_W +: WB_DATA_W];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: if (!wbs_cyc_i) state_d = IDLE;
             else            state_d = we_q ? ACK : WAIT;
      WAIT:  if (!wbs_cyc_i)       state_d = IDLE;
             else if (cnt_q == '0) state_d = ACK;
      ACK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command outputs are registered: the accept edge loads them so they are live during ISSUE.
  always_comb begin
    we_d    = we_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = '1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      IDLE: if (accept) begin
        we_d    = wbs_we_i;
        idx_d   = dec_idx;
        addr_d  = dec_word;
        din_d   = wbs_dat_i;
        web_d   = ~wbs_we_i;
        wmask_d = wbs_we_i ? wr_mask : '0;
        if (idx_valid && !(wbs_we_i && wr_drop))
          for (int i = 0; i < NUM_SRAM; i++)
            if (dec_idx == SEL_W'(i)) csb_d[i] = 1'b0;
      end
      ISSUE: cnt_d = CNT_W'(READ_LAT - 1);
      WAIT: if (wbs_cyc_i) begin
        if (cnt_q == '0) dat_d = rd_word;
        else             cnt_d = cnt_q - 1'b1;
      end
      ACK: ack_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      csb_q   <= '1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      we_q    <= we_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign sram_csb_o   = csb_q;
  assign sram_web_o   = web_q;
  assign sram_wmask_o = wmask_q;
  assign sram_addr_o  = addr_q;
  assign sram_din_o   = din_q;

endmodule
